// File: rtl/gse_pkg.sv
// Shared types and helpers for the game state engine: state and opcode
// encodings, plus the per-stage play-time rule.
package gse_pkg;

    typedef enum logic [2:0] {
        ST_READY       = 3'd1,
        ST_PLAYING     = 3'd2,
        ST_GAME_OVER   = 3'd3,
        ST_STAGE_CLEAR = 3'd4,
        ST_GAME_CLEAR  = 3'd5,
        ST_PAUSED      = 3'd6
    } gse_state_e;

    typedef enum logic [3:0] {
        OP_NOP        = 4'd0,
        OP_HIT        = 4'd1,
        OP_MISS       = 4'd2,
        OP_PAUSE      = 4'd3,
        OP_RESUME     = 4'd4,
        OP_START      = 4'd5,
        OP_NEXT       = 4'd6,
        OP_RESTART    = 4'd7,
        OP_BONUS_LIFE = 4'd8
    } gse_op_e;

    // Play time for 1-based stage s: base minus one step per earlier stage,
    // never below the floor. Compared before subtracting so nothing wraps.
    function automatic int play_sec(input int s, input int base,
                                    input int step, input int floor_sec);
        int red;
        red = (s - 1) * step;
        if (base > red && (base - red) > floor_sec)
            return base - red;
        return floor_sec;
    endfunction

endpackage

// File: rtl/gse_sec_timer.sv
// Seconds countdown: prescaler divides the clock down to one-second steps.
// o_expire is combinational so the parent can act in the same cycle the
// timer would hit zero; o_sec_tick is a registered pulse aligned with the
// new timer value.
module gse_sec_timer #(
    parameter int CLK_HZ    = 1000000,
    parameter int TIMER_W   = 7,
    parameter int RESET_SEC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_run,
    input  logic               i_hold,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    output logic [TIMER_W-1:0] o_timer,
    output logic               o_sec_tick,
    output logic               o_expire
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0]      r_presc;
    logic [TIMER_W-1:0] r_timer;
    logic               r_tick;
    logic               w_wrap;

    // Wrap does not look at i_hold so expire never depends on command accept
    assign w_wrap   = i_run && (r_presc == PRE_MAX);
    assign o_expire = w_wrap && (r_timer == TIMER_W'(1));
    assign o_timer    = r_timer;
    assign o_sec_tick = r_tick;

    // Prescaler and seconds counter; load restarts the second from zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_timer <= TIMER_W'(RESET_SEC);
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap && !i_hold;
            if (i_load) begin
                r_timer <= i_load_val;
                r_presc <= '0;
            end else if (i_run && !i_hold) begin
                if (r_presc == PRE_MAX) begin
                    r_presc <= '0;
                    if (r_timer != '0)
                        r_timer <= r_timer - TIMER_W'(1);
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/game_state_engine.sv
// Game state manager: FSM, stage countdown, lives, combo-weighted score and
// high score, driven by valid/ready commands from the game logic.
module game_state_engine
    import gse_pkg::*;
#(
    parameter int CLK_HZ         = 1000000,
    parameter int NUM_STAGES     = 3,
    parameter int MAX_LIVES      = 3,
    parameter int SCORE_W        = 10,
    parameter int TIMER_W        = 7,
    parameter int READY_SEC      = 4,
    parameter int PLAY_BASE_SEC  = 60,
    parameter int PLAY_STEP_SEC  = 10,
    parameter int MIN_PLAY_SEC   = 20,
    parameter int POINTS_PER_HIT = 1,
    parameter int COMBO_MAX      = 4,
    localparam int LIVES_W       = $clog2(MAX_LIVES + 1),
    localparam int COMBO_W       = $clog2(COMBO_MAX + 1)
) (
    input  logic               clk_1mhz,
    input  logic               rst_n,
    input  logic               cmd_valid,
    input  logic [3:0]         cmd_op,
    output logic               cmd_ready,
    output logic               cmd_done,
    output logic               cmd_err,
    output logic [2:0]         state,
    output logic [2:0]         stage,
    output logic [LIVES_W-1:0] lives,
    output logic [COMBO_W-1:0] combo,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               high_score_updated,
    output logic [TIMER_W-1:0] timer,
    output logic               timer_running,
    output logic               sec_tick
);
    localparam int SUM_W = SCORE_W + 16;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    gse_state_e         r_state, r_origin;
    logic [2:0]         r_stage;
    logic [LIVES_W-1:0] r_lives;
    logic [COMBO_W-1:0] r_combo;
    logic [SCORE_W-1:0] r_score, r_high;
    logic               r_hsu, r_running, r_done, r_err;

    logic               w_expire, w_accept, w_legal, w_do;
    logic               w_start, w_load, w_hold;
    logic [TIMER_W-1:0] w_play, w_load_val;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_hit_score;

    // Expiry owns the cycle; any command waits one cycle
    assign cmd_ready = !w_expire;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_do      = w_accept && w_legal;

    // Which opcodes are legal in the current state
    always_comb begin
        w_legal = 1'b0;
        case (cmd_op)
            OP_NOP, OP_RESTART:              w_legal = 1'b1;
            OP_HIT, OP_MISS, OP_BONUS_LIFE:  w_legal = (r_state == ST_PLAYING);
            OP_PAUSE:                        w_legal = (r_state == ST_PLAYING) || (r_state == ST_READY);
            OP_RESUME:                       w_legal = (r_state == ST_PAUSED);
            OP_START:                        w_legal = (r_state == ST_READY);
            OP_NEXT:                         w_legal = (r_state == ST_STAGE_CLEAR);
            default:                         w_legal = 1'b0;
        endcase
    end

    assign w_play  = TIMER_W'(play_sec(int'(r_stage), PLAY_BASE_SEC, PLAY_STEP_SEC, MIN_PLAY_SEC));
    // START and the READY countdown running out both begin play
    assign w_start = (w_do && cmd_op == OP_START) || (w_expire && r_state == ST_READY);
    assign w_load  = w_start || (w_do && (cmd_op == OP_NEXT || cmd_op == OP_RESTART));
    assign w_load_val = w_start ? w_play : TIMER_W'(READY_SEC);
    // Freeze the prescaler on the PAUSE edge so RESUME picks up exactly there
    assign w_hold  = w_do && (cmd_op == OP_PAUSE);

    assign w_sum = SUM_W'(r_score) + SUM_W'(POINTS_PER_HIT) * SUM_W'(r_combo);
    assign w_hit_score = (w_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : w_sum[SCORE_W-1:0];

    gse_sec_timer #(
        .CLK_HZ    (CLK_HZ),
        .TIMER_W   (TIMER_W),
        .RESET_SEC (READY_SEC)
    ) u_timer (
        .clk        (clk_1mhz),
        .rst_n      (rst_n),
        .i_run      (r_running),
        .i_hold     (w_hold),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_timer    (timer),
        .o_sec_tick (sec_tick),
        .o_expire   (w_expire)
    );

    // Game FSM: expiry transitions first, otherwise the accepted command
    always_ff @(posedge clk_1mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_READY;
            r_origin  <= ST_READY;
            r_stage   <= 3'd1;
            r_lives   <= LIVES_W'(MAX_LIVES);
            r_combo   <= COMBO_W'(1);
            r_score   <= '0;
            r_high    <= '0;
            r_hsu     <= 1'b0;
            r_running <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_accept && w_legal;
            r_err  <= w_accept && !w_legal;
            if (w_expire) begin
                case (r_state)
                    ST_READY: begin
                        r_state <= ST_PLAYING;
                        r_combo <= COMBO_W'(1);
                    end
                    ST_PLAYING: begin
                        r_running <= 1'b0;
                        if (r_stage < 3'(NUM_STAGES)) begin
                            r_state <= ST_STAGE_CLEAR;
                        end else begin
                            r_state <= ST_GAME_CLEAR;
                            if (r_score > r_high) begin
                                r_high <= r_score;
                                r_hsu  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end else if (w_do) begin
                case (cmd_op)
                    OP_HIT: begin
                        r_score <= w_hit_score;
                        if (r_combo < COMBO_W'(COMBO_MAX))
                            r_combo <= r_combo + COMBO_W'(1);
                    end
                    OP_MISS: begin
                        r_combo <= COMBO_W'(1);
                        if (r_lives <= LIVES_W'(1)) begin
                            r_lives   <= '0;
                            r_state   <= ST_GAME_OVER;
                            r_running <= 1'b0;
                            if (r_score > r_high) begin
                                r_high <= r_score;
                                r_hsu  <= 1'b1;
                            end
                        end else begin
                            r_lives <= r_lives - LIVES_W'(1);
                        end
                    end
                    OP_PAUSE: begin
                        r_origin  <= r_state;
                        r_state   <= ST_PAUSED;
                        r_running <= 1'b0;
                    end
                    OP_RESUME: begin
                        r_state   <= r_origin;
                        r_running <= 1'b1;
                    end
                    OP_START: begin
                        r_state <= ST_PLAYING;
                        r_combo <= COMBO_W'(1);
                    end
                    OP_NEXT: begin
                        r_stage   <= r_stage + 3'd1;
                        r_state   <= ST_READY;
                        r_running <= 1'b1;
                    end
                    OP_RESTART: begin
                        r_stage   <= 3'd1;
                        r_lives   <= LIVES_W'(MAX_LIVES);
                        r_score   <= '0;
                        r_combo   <= COMBO_W'(1);
                        r_state   <= ST_READY;
                        r_running <= 1'b1;
                        r_hsu     <= 1'b0;
                    end
                    OP_BONUS_LIFE: begin
                        if (r_lives < LIVES_W'(MAX_LIVES))
                            r_lives <= r_lives + LIVES_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cmd_done           = r_done;
    assign cmd_err            = r_err;
    assign state              = r_state;
    assign stage              = r_stage;
    assign lives              = r_lives;
    assign combo              = r_combo;
    assign score              = r_score;
    assign high_score         = r_high;
    assign high_score_updated = r_hsu;
    assign timer_running      = r_running;

endmodule

// File: tb/tb_game_state_engine.sv
// Directed bench for game_state_engine with a small, fast configuration.
// Expected values are queued as each step is driven and drained against the
// DUT once the step's clock edge has passed.
module tb_game_state_engine;

    logic       clk, rst_n, cmd_valid;
    logic [3:0] cmd_op;
    logic       cmd_ready, cmd_done, cmd_err;
    logic [2:0] state, stage;
    logic [1:0] lives;
    logic [2:0] combo;
    logic [9:0] score, high_score;
    logic       high_score_updated;
    logic [6:0] timer;
    logic       timer_running, sec_tick;

    game_state_engine #(
        .CLK_HZ(10), .NUM_STAGES(3), .MAX_LIVES(3), .SCORE_W(10), .TIMER_W(7),
        .READY_SEC(4), .PLAY_BASE_SEC(6), .PLAY_STEP_SEC(2), .MIN_PLAY_SEC(2),
        .POINTS_PER_HIT(1), .COMBO_MAX(4)
    ) dut (
        .clk_1mhz(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
        .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .state(state), .stage(stage), .lives(lives), .combo(combo),
        .score(score), .high_score(high_score),
        .high_score_updated(high_score_updated), .timer(timer),
        .timer_running(timer_running), .sec_tick(sec_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {F_STATE, F_STAGE, F_LIVES, F_COMBO, F_SCORE, F_HIGH, F_HSU,
                  F_TIMER, F_RUN, F_TICK, F_READY, F_DONE, F_ERR, F_NTICK} fld_t;
    typedef struct { fld_t f; logic [31:0] v; } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    function automatic logic [31:0] obs(input fld_t f);
        case (f)
            F_STATE: return 32'(state);
            F_STAGE: return 32'(stage);
            F_LIVES: return 32'(lives);
            F_COMBO: return 32'(combo);
            F_SCORE: return 32'(score);
            F_HIGH:  return 32'(high_score);
            F_HSU:   return 32'(high_score_updated);
            F_TIMER: return 32'(timer);
            F_RUN:   return 32'(timer_running);
            F_TICK:  return 32'(sec_tick);
            F_READY: return 32'(cmd_ready);
            F_DONE:  return 32'(cmd_done);
            F_ERR:   return 32'(cmd_err);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic cmp(input fld_t f, input logic [31:0] o, input logic [31:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", f.name(), o, e);
        end
    endtask

    task automatic ex(input fld_t f, input int v);
        exp_t e;
        e.f = f;
        e.v = 32'(v);
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.f, obs(e.f), e.v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
    endtask

    // Bounded wait for the FSM to leave a state
    task automatic wait_leave(input logic [2:0] st);
        int n;
        n = 0;
        while (state === st && n < 200) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int ntick;
        int hit_exp[5];
        hit_exp = '{1, 3, 6, 10, 14};
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'd0;
        repeat (2) tick();

        // reset values
        ex(F_STATE, 1); ex(F_STAGE, 1); ex(F_LIVES, 3); ex(F_COMBO, 1);
        ex(F_SCORE, 0); ex(F_HIGH, 0); ex(F_HSU, 0); ex(F_TIMER, 4);
        ex(F_RUN, 1); ex(F_TICK, 0); ex(F_DONE, 0); ex(F_ERR, 0); ex(F_READY, 1);
        drain();
        rst_n = 1'b1;

        // ready countdown: tick every 10 cycles, expiry on the 40th
        for (int k = 1; k <= 4; k++) begin
            repeat (9) tick();
            ex(F_TICK, 0);
            drain();
            tick();
            ex(F_TICK, 1);
            if (k < 4) begin
                ex(F_TIMER, 4 - k); ex(F_STATE, 1);
            end else begin
                ex(F_TIMER, 6); ex(F_STATE, 2); ex(F_COMBO, 1);
            end
            drain();
        end

        // combo-weighted scoring
        for (int i = 0; i < 5; i++) begin
            ex(F_SCORE, hit_exp[i]); ex(F_DONE, 1);
            issue(4'd1);
            drain();
        end
        ex(F_COMBO, 4);
        drain();
        ex(F_COMBO, 1); ex(F_LIVES, 2); ex(F_SCORE, 14);
        issue(4'd2); drain();
        ex(F_SCORE, 15); ex(F_COMBO, 2);
        issue(4'd1); drain();

        // bonus life saturates at MAX_LIVES
        ex(F_LIVES, 3); issue(4'd8); drain();
        ex(F_LIVES, 3); ex(F_DONE, 1); issue(4'd8); drain();

        // lose all lives
        ex(F_LIVES, 2); issue(4'd2); drain();
        ex(F_LIVES, 1); issue(4'd2); drain();
        ex(F_LIVES, 0); ex(F_STATE, 3); ex(F_HIGH, 15); ex(F_HSU, 1); ex(F_RUN, 0);
        issue(4'd2); drain();

        // GAME_OVER rejects HIT
        ex(F_ERR, 1); ex(F_DONE, 0); ex(F_SCORE, 15);
        issue(4'd1); drain();

        // RESTART keeps high score
        ex(F_SCORE, 0); ex(F_HIGH, 15); ex(F_HSU, 0); ex(F_STATE, 1); ex(F_STAGE, 1);
        ex(F_LIVES, 3); ex(F_TIMER, 4); ex(F_RUN, 1); ex(F_COMBO, 1);
        issue(4'd7); drain();

        // unknown opcode
        ex(F_ERR, 1); ex(F_STATE, 1); issue(4'd9); drain();

        // pause from READY and back
        ex(F_STATE, 6); ex(F_RUN, 0); issue(4'd3); drain();
        ex(F_STATE, 1); ex(F_RUN, 1); issue(4'd4); drain();

        // START skips the countdown
        ex(F_STATE, 2); ex(F_TIMER, 6); ex(F_COMBO, 1);
        issue(4'd5); drain();

        // pause with timer=5, prescaler=7
        repeat (17) tick();
        ex(F_TIMER, 5); drain();
        ex(F_STATE, 6); ex(F_TIMER, 5); ex(F_RUN, 0);
        issue(4'd3); drain();
        ntick = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sec_tick === 1'b1) ntick++;
        end
        cmp(F_NTICK, 32'(ntick), 32'd0);
        ex(F_TIMER, 5); drain();
        ex(F_STATE, 2); ex(F_RUN, 1); issue(4'd4); drain();
        tick(); ex(F_TICK, 0); drain();
        tick(); ex(F_TICK, 0); drain();
        tick(); ex(F_TICK, 1); ex(F_TIMER, 4); drain();

        // six hits: 1,2,3,4,4,4
        repeat (6) issue(4'd1);
        ex(F_SCORE, 18); drain();

        // stage 1 expiry
        wait_leave(3'd2);
        ex(F_STATE, 4); ex(F_RUN, 0); ex(F_TIMER, 0); ex(F_STAGE, 1);
        drain();

        // NEXT to stage 2, play time 4
        ex(F_STAGE, 2); ex(F_STATE, 1); ex(F_TIMER, 4); ex(F_SCORE, 18); ex(F_LIVES, 3);
        issue(4'd6); drain();
        ex(F_STATE, 2); ex(F_TIMER, 4); issue(4'd5); drain();
        ex(F_ERR, 1); ex(F_STATE, 2); issue(4'd6); drain();

        // HIT held across the expiry cycle
        repeat (38) tick();
        ex(F_READY, 0); ex(F_TIMER, 1); drain();
        cmd_valid = 1'b1; cmd_op = 4'd1;
        tick();
        ex(F_STATE, 4); ex(F_DONE, 0); ex(F_ERR, 0); ex(F_TICK, 1); ex(F_READY, 1);
        drain();
        tick();
        cmd_valid = 1'b0; cmd_op = 4'd0;
        ex(F_ERR, 1); ex(F_SCORE, 18); ex(F_STATE, 4);
        drain();

        // stage 3, play time floor 2, ends in GAME_CLEAR
        ex(F_STAGE, 3); ex(F_STATE, 1); issue(4'd6); drain();
        ex(F_TIMER, 2); ex(F_STATE, 2); issue(4'd5); drain();
        wait_leave(3'd2);
        ex(F_STATE, 5); ex(F_HIGH, 18); ex(F_HSU, 1); ex(F_RUN, 0); ex(F_STAGE, 3);
        drain();
        ex(F_ERR, 1); ex(F_STATE, 5); issue(4'd6); drain();
        ex(F_STATE, 1); ex(F_HIGH, 18); ex(F_HSU, 0); ex(F_SCORE, 0); ex(F_STAGE, 1);
        issue(4'd7); drain();

        // asynchronous reset mid-game clears high score too
        issue(4'd5);
        ex(F_SCORE, 1); issue(4'd1); drain();
        #2 rst_n = 1'b0;
        #1;
        ex(F_STATE, 1); ex(F_HIGH, 0); ex(F_SCORE, 0); ex(F_TIMER, 4); ex(F_RUN, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
